// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter in front of a single-port data memory, with a
// built-in sweep that zeroes the whole memory on request.
//
// Parameters
//   p_WORD_LEN      data word width
//   p_ADDR_LEN      address width
//   p_DATA_MEM_SIZE number of words swept by a clear (power of two)
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A (CPU) request, write-not-read, address, data
//   a_gnt, a_rdata             port A grant and registered read data
//   b_*                        port B (debug/DMA), same shape as port A
//   clr_start                  pulse requesting a full memory clear
//   clr_busy, clr_done         clear in progress; one-cycle completion pulse
//   mem_address/mem_dataIn/mem_writeEn  shared memory port, driven from state
//   mem_dataOut                asynchronous read data from the memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_ADDR_LEN      = 16,
    parameter int p_DATA_MEM_SIZE = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [p_ADDR_LEN-1:0] a_addr,
    input  logic [p_WORD_LEN-1:0] a_wdata,
    output logic                  a_gnt,
    output logic [p_WORD_LEN-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [p_ADDR_LEN-1:0] b_addr,
    input  logic [p_WORD_LEN-1:0] b_wdata,
    output logic                  b_gnt,
    output logic [p_WORD_LEN-1:0] b_rdata,

    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,

    output logic [p_ADDR_LEN-1:0] mem_address,
    output logic [p_WORD_LEN-1:0] mem_dataIn,
    output logic                  mem_writeEn,
    input  logic [p_WORD_LEN-1:0] mem_dataOut
);

    localparam int CNT_W = (p_DATA_MEM_SIZE > 1) ? $clog2(p_DATA_MEM_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(p_DATA_MEM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic                    last_b_q,   last_b_d;    // 1: port B was served last
    logic [CNT_W-1:0]        clr_cnt_q,  clr_cnt_d;
    logic                    a_gnt_q,    a_gnt_d;
    logic                    b_gnt_q,    b_gnt_d;
    logic                    clr_busy_q, clr_busy_d;
    logic                    clr_done_q, clr_done_d;
    logic [p_WORD_LEN-1:0]   a_rdata_q,  a_rdata_d;
    logic [p_WORD_LEN-1:0]   b_rdata_q,  b_rdata_d;

    logic                    pick_a;
    logic                    pick_b;
    state_t                  arb_state;

    // Next-state / next-output logic.
    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        clr_cnt_d  = clr_cnt_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        clr_done_d = 1'b0;

        // Round-robin: on a tie the port that was not served last wins.
        pick_a    = a_req && (!b_req || last_b_q);
        pick_b    = b_req && !pick_a;
        arb_state = pick_a ? SERVE_A : (pick_b ? SERVE_B : IDLE);

        case (state_q)
            CLEAR: begin
                // clr_start is deliberately not looked at while sweeping.
                clr_cnt_d = clr_cnt_q + CNT_W'(1);
                if (clr_cnt_q == CNT_LAST) begin
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                    state_d    = arb_state;
                end
            end
            default: begin
                state_d = clr_start ? CLEAR : arb_state;
            end
        endcase

        if (state_d == SERVE_A) last_b_d = 1'b0;
        if (state_d == SERVE_B) last_b_d = 1'b1;

        // Read data is captured at the edge that ends the grant cycle.
        if (state_q == SERVE_A && !a_we) a_rdata_d = mem_dataOut;
        if (state_q == SERVE_B && !b_we) b_rdata_d = mem_dataOut;

        a_gnt_d    = (state_d == SERVE_A);
        b_gnt_d    = (state_d == SERVE_B);
        clr_busy_d = (state_d == CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            clr_cnt_q  <= '0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            clr_cnt_q  <= clr_cnt_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    // Shared memory port follows the current state. Requesters hold their
    // address/data stable through the grant, so nothing is latched here.
    always_comb begin
        mem_address = '0;
        mem_dataIn  = '0;
        mem_writeEn = 1'b0;
        case (state_q)
            SERVE_A: begin
                mem_address = a_addr;
                mem_dataIn  = a_wdata;
                mem_writeEn = a_we;
            end
            SERVE_B: begin
                mem_address = b_addr;
                mem_dataIn  = b_wdata;
                mem_writeEn = b_we;
            end
            CLEAR: begin
                mem_address = p_ADDR_LEN'(clr_cnt_q);
                mem_writeEn = 1'b1;
            end
            default: ;
        endcase
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule
